// File: rtl/syncer_handshake_tx.sv
// Source half of a two-phase req/ack bus synchronizer: captures a word on valid/ready,
// toggles xfer_req and holds xfer_data until the synchronized xfer_ack phase matches.
module syncer_handshake_tx #(
  parameter int unsigned      WIDTH          = 32,
  parameter int unsigned      SYNC_STAGES    = 2,
  parameter int unsigned      TIMEOUT_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_DATA     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             xfer_req,
  output logic [WIDTH-1:0] xfer_data,
  input  logic             xfer_ack,
  output logic             done,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clear
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  (* ASYNC_REG = "TRUE" *)
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [SYNC_STAGES-1:0] ack_sync_d;
  logic                   ack_s;
  logic                   err_set;

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    data_d     = data_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    err_set    = 1'b0;
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], xfer_ack};

    if (state_q == IDLE) begin
      if (in_valid) begin
        data_d  = in_data;
        req_d   = ~req_q;
        state_d = WAIT_ACK;
        cnt_d   = '0;
      end
    end else begin
      // Completion is phase equality, so a missed toggle can never wedge the pair.
      if (ack_s == req_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Fires once, on the step into saturation, so a clear while still waiting sticks.
        if (TO_EN && (cnt_q == CNT_MAX - CNT_W'(1))) begin
          err_set = 1'b1;
        end
      end
    end

    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      data_q     <= RESET_DATA;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      ack_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q == WAIT_ACK);
  assign xfer_req    = req_q;
  assign xfer_data   = data_q;
  assign done        = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_syncer_handshake_tx.sv
// Directed bench for syncer_handshake_tx with a behavioural destination ack model.
module tb_syncer_handshake_tx;

  localparam int          WIDTH    = 32;
  localparam int          SYNC     = 2;
  localparam int          TO       = 16;
  localparam logic [31:0] RST_DATA = 32'hA5A5_5A5A;

  logic             clk    = 1'b0;
  logic             resetn = 1'b1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             xfer_req;
  logic [WIDTH-1:0] xfer_data;
  logic             xfer_ack;
  logic             done;
  logic             busy;
  logic             timeout_err;
  logic             err_clear;

  logic ack_reg;
  logic loop_en;
  logic exp_req;
  int   checks = 0;
  int   passed = 0;

  assign xfer_ack = loop_en ? xfer_req : ack_reg;

  always #5 clk = ~clk;

  syncer_handshake_tx #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .RESET_DATA(RST_DATA)
  ) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_ack(xfer_ack), .done(done),
    .busy(busy), .timeout_err(timeout_err), .err_clear(err_clear)
  );

  task automatic test_reset;
    in_valid = 0; in_data = '0; err_clear = 0; ack_reg = 0; loop_en = 0;
    #1 resetn = 0;
    #2;
    checks++; if (xfer_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", xfer_req); else passed++;
    checks++; if (xfer_data !== RST_DATA) $display("FAIL reset_data: got %h expected %h", xfer_data, RST_DATA); else passed++;
    checks++; if (done !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_flags: got done=%b err=%b busy=%b expected 0 0 0", done, timeout_err, busy); else passed++;
    repeat (2) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: got in_ready=%b busy=%b expected 1 0", in_ready, busy); else passed++;
    exp_req = 0;
  endtask

  task automatic test_basic;
    int bad = 0;
    in_valid = 1; in_data = 32'hDEADBEEF;
    @(negedge clk);
    in_valid = 0; in_data = '0;
    exp_req = ~exp_req;
    checks++; if (xfer_req !== exp_req || xfer_data !== 32'hDEADBEEF)
      $display("FAIL basic_launch: got req=%b data=%h expected %b DEADBEEF", xfer_req, xfer_data, exp_req); else passed++;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL basic_busy: got busy=%b in_ready=%b expected 1 0", busy, in_ready); else passed++;
    repeat (4) begin
      @(negedge clk);
      if (xfer_data !== 32'hDEADBEEF || done !== 1'b0 || busy !== 1'b1) bad++;
    end
    ack_reg = exp_req;
    repeat (2) begin
      @(negedge clk);
      if (xfer_data !== 32'hDEADBEEF || done !== 1'b0 || busy !== 1'b1) bad++;
    end
    @(negedge clk);
    checks++; if (done !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL basic_done: got done=%b in_ready=%b busy=%b expected 1 1 0", done, in_ready, busy); else passed++;
    checks++; if (bad !== 0) $display("FAIL basic_hold: got %0d bad cycles expected 0", bad); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL basic_pulse: got done=%b expected 0", done); else passed++;
  endtask

  task automatic test_back_to_back;
    int   cyc = 0, words = 0, dones = 0, run = 0, bad_run = 0, bad_word = 0;
    logic prev_busy = 0;
    loop_en = 1; in_valid = 1; in_data = '0;
    while ((words < 8 || busy) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) dones++;
      if (busy && !prev_busy) begin
        exp_req = ~exp_req;
        if (xfer_data !== 32'(words) || xfer_req !== exp_req) bad_word++;
        words++;
        run = 0;
      end
      if (busy) run++;
      if (!busy && prev_busy && run != SYNC + 1) bad_run++;
      prev_busy = busy;
      if (words >= 8) in_valid = 0;
      in_data = 32'(words);
    end
    checks++; if (cyc >= 200) $display("FAIL b2b_budget: got %0d cycles expected < 200", cyc); else passed++;
    checks++; if (words !== 8 || bad_word !== 0)
      $display("FAIL b2b_words: got words=%0d bad=%0d expected 8 0", words, bad_word); else passed++;
    checks++; if (dones !== 8) $display("FAIL b2b_done: got %0d pulses expected 8", dones); else passed++;
    checks++; if (bad_run !== 0) $display("FAIL b2b_occupancy: got %0d bad runs expected 0", bad_run); else passed++;
    ack_reg = exp_req;
    loop_en = 0;
  endtask

  task automatic test_timeout;
    in_valid = 1; in_data = 32'h1234_5678;
    @(negedge clk);
    in_valid = 0;
    exp_req = ~exp_req;
    repeat (15) @(negedge clk);
    checks++; if (timeout_err !== 1'b0) $display("FAIL timeout_early: got %b expected 0", timeout_err); else passed++;
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b1)
      $display("FAIL timeout_fire: got err=%b busy=%b expected 1 1", timeout_err, busy); else passed++;
    repeat (23) @(negedge clk);
    checks++; if (busy !== 1'b1 || timeout_err !== 1'b1 || xfer_data !== 32'h1234_5678)
      $display("FAIL timeout_wait: got busy=%b err=%b data=%h expected 1 1 12345678", busy, timeout_err, xfer_data); else passed++;
    ack_reg = exp_req;
    repeat (2) @(negedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b1 || timeout_err !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL timeout_late_ack: got done=%b err=%b in_ready=%b expected 1 1 1", done, timeout_err, in_ready); else passed++;
    err_clear = 1;
    @(negedge clk);
    err_clear = 0;
    checks++; if (timeout_err !== 1'b0) $display("FAIL timeout_clear: got %b expected 0", timeout_err); else passed++;
  endtask

  task automatic test_clear_collision;
    in_valid = 1; in_data = 32'h0000_C011;
    @(negedge clk);
    in_valid = 0;
    exp_req = ~exp_req;
    repeat (15) @(negedge clk);
    err_clear = 1;
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) $display("FAIL collide_set_wins: got %b expected 1", timeout_err); else passed++;
    @(negedge clk);
    err_clear = 0;
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1)
      $display("FAIL collide_clear: got err=%b busy=%b expected 0 1", timeout_err, busy); else passed++;
    ack_reg = exp_req;
    repeat (2) @(negedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b1 || timeout_err !== 1'b0)
      $display("FAIL collide_done: got done=%b err=%b expected 1 0", done, timeout_err); else passed++;
  endtask

  task automatic test_hold_busy;
    int bad = 0;
    in_valid = 1; in_data = 32'hCAFE_F00D;
    @(negedge clk);
    exp_req = ~exp_req;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h1000_0000 + 32'(i);
      @(negedge clk);
      if (xfer_data !== 32'hCAFE_F00D || in_ready !== 1'b0) bad++;
    end
    ack_reg = exp_req;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'h2000_0000 + 32'(i);
      @(negedge clk);
      if (xfer_data !== 32'hCAFE_F00D || in_ready !== 1'b0) bad++;
    end
    @(negedge clk);
    checks++; if (done !== 1'b1 || in_ready !== 1'b1 || xfer_data !== 32'hCAFE_F00D)
      $display("FAIL hold_done: got done=%b in_ready=%b data=%h expected 1 1 CAFEF00D", done, in_ready, xfer_data); else passed++;
    in_valid = 0;
    checks++; if (bad !== 0) $display("FAIL hold_stable: got %0d bad cycles expected 0", bad); else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || xfer_req !== exp_req)
      $display("FAIL hold_idle: got busy=%b req=%b expected 0 %b", busy, xfer_req, exp_req); else passed++;
  endtask

  task automatic test_reset_midop;
    in_valid = 1; in_data = 32'h0BAD_CAFE;
    @(negedge clk);
    in_valid = 0;
    exp_req = ~exp_req;
    checks++; if (xfer_req !== 1'b1 || busy !== 1'b1)
      $display("FAIL midop_pre: got req=%b busy=%b expected 1 1", xfer_req, busy); else passed++;
    @(negedge clk);
    #2 resetn = 0; ack_reg = 0;
    #1;
    checks++; if (xfer_req !== 1'b0 || xfer_data !== RST_DATA || busy !== 1'b0)
      $display("FAIL midop_async: got req=%b data=%h busy=%b expected 0 %h 0", xfer_req, xfer_data, busy, RST_DATA); else passed++;
    @(negedge clk);
    resetn = 1;
    exp_req = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL midop_ready: got %b expected 1", in_ready); else passed++;
    in_valid = 1; in_data = 32'h7777_0001;
    @(negedge clk);
    in_valid = 0;
    exp_req = ~exp_req;
    checks++; if (xfer_req !== 1'b1 || xfer_data !== 32'h7777_0001)
      $display("FAIL midop_fresh: got req=%b data=%h expected 1 77770001", xfer_req, xfer_data); else passed++;
    ack_reg = exp_req;
    repeat (2) @(negedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL midop_done: got done=%b in_ready=%b expected 1 1", done, in_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_clear_collision();
    test_hold_busy();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
